// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the count_ctrl sequencer.
//   cc_state_t : sequencer states (IDLE, RUN, PAUSE, DONE)
//   CC_WIDTH   : default counter datapath width
//   CC_DIV_W   : default prescaler divide-value width
package count_ctrl_pkg;

  localparam int unsigned CC_WIDTH = 8;
  localparam int unsigned CC_DIV_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cc_state_t;

endpackage

// File: rtl/tick_div.sv
// Prescaler for count_ctrl. Counts 0..div while enabled and raises tick on the
// cycle the count equals div, returning to 0 on that cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : advance the prescaler this cycle (count held otherwise)
//   clr   : synchronous clear to 0, wins over en
//   div   : divide value; tick every div+1 enabled cycles
//   tick  : combinational step strobe, only while en
module tick_div
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = CC_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// Sequencer for an external counter register that reloads from v every clock.
// Computes the next counter value from the fed-back count: hold, preload, or a
// prescaled up/down step that either stops or wraps at the terminal value.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start/stop : begin-or-resume / pause pulses
//   cfg_load   : preload pulse, v takes cfg_val
//   cfg_val    : preload value
//   cfg_limit  : up-count terminal value; down-count wrap reload value
//   cfg_down   : 1 = count down, 0 = count up
//   cfg_wrap   : 1 = wrap at terminal, 0 = stop (DONE) at terminal
//   cfg_div    : step every cfg_div+1 cycles while running
//   count      : current counter value (feedback)
//   ld         : v is a load or step rather than a hold
//   v          : next counter value (combinational)
//   busy       : registered, 1 while in RUN
//   done/wrap  : registered one-cycle status pulses
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = CC_WIDTH,
  parameter int unsigned DIV_W = CC_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_val,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_down,
  input  logic             cfg_wrap,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [WIDTH-1:0] count,
  output logic             ld,
  output logic [WIDTH-1:0] v,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  cc_state_t state_q, state_d;
  logic      busy_q, done_q, done_d, wrap_q, wrap_d;
  logic      div_en, div_clr, step, terminal, idle_or_done;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);

  // Load and stop both suppress the step, so the prescaler must not advance either.
  assign div_en  = (state_q == RUN) && !cfg_load && !stop;
  assign div_clr = cfg_load || (start && idle_or_done);

  tick_div #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (div_en),
    .clr  (div_clr),
    .div  (cfg_div),
    .tick (step)
  );

  assign terminal = cfg_down ? (count == '0) : (count >= cfg_limit);

  // Priority: cfg_load > stop > start > step. Reset forces hold.
  always_comb begin
    state_d = state_q;
    v       = count;
    ld      = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (rst_n) begin
      if (cfg_load) begin
        v  = cfg_val;
        ld = 1'b1;
        if (state_q == DONE) begin
          state_d = IDLE;
        end
      end else if (stop && (state_q == RUN)) begin
        state_d = PAUSE;
      end else if (start && (state_q != RUN)) begin
        state_d = RUN;
      end else if (step) begin
        if (!terminal) begin
          v  = cfg_down ? count - WIDTH'(1) : count + WIDTH'(1);
          ld = 1'b1;
        end else if (cfg_wrap) begin
          v      = cfg_down ? cfg_limit : '0;
          ld     = 1'b1;
          wrap_d = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl with the counter register closing the loop.
module tb_count_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, cfg_load, cfg_down, cfg_wrap;
  logic [WIDTH-1:0] cfg_val, cfg_limit, count, v;
  logic [DIV_W-1:0] cfg_div;
  logic             ld, busy, done, wrap;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_ctrl #(
    .WIDTH(WIDTH),
    .DIV_W(DIV_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .cfg_load (cfg_load),
    .cfg_val  (cfg_val),
    .cfg_limit(cfg_limit),
    .cfg_down (cfg_down),
    .cfg_wrap (cfg_wrap),
    .cfg_div  (cfg_div),
    .count    (count),
    .ld       (ld),
    .v        (v),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  // Counter register: reloads from v every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= v;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_load = 1'b0; cfg_val = '0;
    cfg_limit = '0; cfg_down = 1'b0; cfg_wrap = 1'b0; cfg_div = '0;
    cyc(); cyc();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    check("rst_ld", ld, 0);
    check("rst_v", v, 0);
    rst_n = 1'b1;
    cyc();

    // 1: preload 5, up to limit 8, stop at terminal
    cfg_limit = 8'd8; cfg_load = 1'b1; cfg_val = 8'd5;
    #1;
    check("t1_load_ld", ld, 1);
    check("t1_load_v", v, 5);
    cyc(); cfg_load = 1'b0;
    check("t1_cnt5", count, 5);
    check("t1_idle_busy", busy, 0);
    start = 1'b1;
    cyc(); start = 1'b0;
    check("t1_run_busy", busy, 1);
    check("t1_cnt_still5", count, 5);
    #1;
    check("t1_v6", v, 6);
    cyc(); check("t1_cnt6", count, 6);
    cyc(); check("t1_cnt7", count, 7);
    cyc(); check("t1_cnt8", count, 8);
    check("t1_done_early", done, 0);
    #1;
    check("t1_term_ld", ld, 0);
    check("t1_term_v", v, 8);
    cyc();
    check("t1_done", done, 1);
    check("t1_busy_drop", busy, 0);
    check("t1_hold8", count, 8);
    cyc();
    check("t1_done_once", done, 0);
    check("t1_hold8b", count, 8);

    // 2: up, limit 3, wrap, div 2, from 0
    cfg_limit = 8'd3; cfg_wrap = 1'b1; cfg_div = 4'd2;
    cfg_load = 1'b1; cfg_val = 8'd0;
    cyc(); cfg_load = 1'b0;
    check("t2_cnt0", count, 0);
    check("t2_idle_busy", busy, 0);
    start = 1'b1;
    cyc(); start = 1'b0;
    check("t2_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(); check("t2_hold_a", count, (k - 1) % 4);
      cyc(); check("t2_hold_b", count, (k - 1) % 4);
      cyc(); check("t2_step", count, k % 4);
      check("t2_wrap", wrap, (k == 4) ? 1 : 0);
    end
    cyc();
    check("t2_wrap_once", wrap, 0);
    check("t2_still_run", busy, 1);

    // 3: down, wrap, limit 10, from 1, div 0
    cfg_down = 1'b1; cfg_limit = 8'd10; cfg_div = 4'd0;
    cfg_load = 1'b1; cfg_val = 8'd1;
    cyc(); cfg_load = 1'b0;
    check("t3_cnt1", count, 1);
    cyc(); check("t3_cnt0", count, 0);
    check("t3_nowrap", wrap, 0);
    cyc(); check("t3_cnt10", count, 10);
    check("t3_wrap", wrap, 1);
    cyc(); check("t3_cnt9", count, 9);
    check("t3_wrap_once", wrap, 0);

    // 4: pause at 4, resume
    cfg_down = 1'b0; cfg_wrap = 1'b0; cfg_limit = 8'd250;
    cfg_load = 1'b1; cfg_val = 8'd3;
    cyc(); cfg_load = 1'b0;
    check("t4_cnt3", count, 3);
    cyc(); check("t4_cnt4", count, 4);
    stop = 1'b1;
    #1;
    check("t4_stop_ld", ld, 0);
    check("t4_stop_v", v, 4);
    cyc(); stop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("t4_pause_cnt", count, 4);
      check("t4_pause_busy", busy, 0);
      cyc();
    end
    start = 1'b1;
    cyc(); start = 1'b0;
    check("t4_resume_busy", busy, 1);
    check("t4_resume_cnt", count, 4);
    cyc(); check("t4_cnt5", count, 5);

    // 5: load beats stop and a due step
    cfg_load = 1'b1; cfg_val = 8'd200; stop = 1'b1;
    #1;
    check("t5_v", v, 200);
    check("t5_ld", ld, 1);
    cyc(); cfg_load = 1'b0; stop = 1'b0;
    check("t5_cnt200", count, 200);
    check("t5_busy", busy, 1);
    cyc(); check("t5_cnt201", count, 201);

    // 6: asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_wrap", wrap, 0);
    check("t6_ld", ld, 0);
    check("t6_v", v, count);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("t6_idle_busy", busy, 0);
    check("t6_idle_ld", ld, 0);
    cyc();
    check("t6_idle_cnt", count, 0);
    start = 1'b1;
    cyc(); start = 1'b0;
    check("t6_start_busy", busy, 1);
    cyc(); check("t6_cnt1", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
